// File: rtl/if_fetch_queue_if.sv
// Fetch-stage bus: PC register strobe, instruction-memory request/response,
// redirect, and the decode-side valid/ready head.
interface if_fetch_queue_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic [ADDR_W-1:0] pc_in;
  logic              pc_advance;
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_gnt;
  logic              imem_rvalid;
  logic [DATA_W-1:0] imem_rdata;
  logic              flush;
  logic              id_valid;
  logic [DATA_W-1:0] id_instr;
  logic [ADDR_W-1:0] id_pc;
  logic              id_ready;

  modport master (
    input  pc_in, imem_gnt, imem_rvalid, imem_rdata, flush, id_ready,
    output pc_advance, imem_req, imem_addr, id_valid, id_instr, id_pc
  );

  modport slave (
    output pc_in, imem_gnt, imem_rvalid, imem_rdata, flush, id_ready,
    input  pc_advance, imem_req, imem_addr, id_valid, id_instr, id_pc
  );
endinterface

// File: rtl/if_fetch_queue.sv
// Instruction-fetch queue: issues imem requests at pc_in, buffers in-order
// {pc, instr} pairs for decode, and discards in-flight responses on flush.
module if_fetch_queue #(
  parameter int DEPTH  = 2,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  if_fetch_queue_if.master  bus
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [CNT_W-1:0] cnt_t;
  typedef logic [CNT_W:0]   wcnt_t;

  localparam wcnt_t DEPTH_W = wcnt_t'(DEPTH);

  logic [ADDR_W-1:0] pc_q    [DEPTH];
  logic [DATA_W-1:0] instr_q [DEPTH];
  logic [DEPTH-1:0]  filled_q;
  ptr_t              head_q, tail_q, fill_q;
  cnt_t              alloc_q, unfilled_q, drop_q;

  logic  pop, grant, req, rsp_drop, rsp_fill;
  wcnt_t used;

  function automatic ptr_t ptr_inc(input ptr_t p);
    if (p == ptr_t'(DEPTH - 1)) return '0;
    return ptr_t'(p + 1'b1);
  endfunction

  assign bus.id_valid = filled_q[head_q] && !bus.flush;
  assign bus.id_instr = instr_q[head_q];
  assign bus.id_pc    = pc_q[head_q];
  assign pop          = bus.id_valid && bus.id_ready;

  // Credit counts responses owed to dropped entries; a same-cycle pop frees a slot.
  assign used  = wcnt_t'(alloc_q) + wcnt_t'(drop_q) - wcnt_t'(pop);
  assign req   = !reset && !bus.flush && (used < DEPTH_W);
  assign grant = req && bus.imem_gnt;

  assign bus.imem_req   = req;
  assign bus.imem_addr  = bus.pc_in;
  assign bus.pc_advance = grant;

  assign rsp_drop = bus.imem_rvalid && (drop_q != '0);
  assign rsp_fill = bus.imem_rvalid && (drop_q == '0) && (unfilled_q != '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q     <= '0;
      tail_q     <= '0;
      fill_q     <= '0;
      alloc_q    <= '0;
      unfilled_q <= '0;
      drop_q     <= '0;
      filled_q   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_q[i]    <= '0;
        instr_q[i] <= '0;
      end
    end else if (bus.flush) begin
      // Every unfilled entry still has a response coming; those become drops.
      drop_q     <= drop_q + unfilled_q - cnt_t'(rsp_drop || rsp_fill);
      head_q     <= '0;
      tail_q     <= '0;
      fill_q     <= '0;
      alloc_q    <= '0;
      unfilled_q <= '0;
      filled_q   <= '0;
    end else begin
      if (pop) begin
        filled_q[head_q] <= 1'b0;
        head_q           <= ptr_inc(head_q);
      end
      if (grant) begin
        pc_q[tail_q]     <= bus.pc_in;
        filled_q[tail_q] <= 1'b0;
        tail_q           <= ptr_inc(tail_q);
      end
      if (rsp_fill) begin
        instr_q[fill_q]  <= bus.imem_rdata;
        filled_q[fill_q] <= 1'b1;
        fill_q           <= ptr_inc(fill_q);
      end
      if (rsp_drop) drop_q <= drop_q - 1'b1;
      alloc_q    <= alloc_q + cnt_t'(grant) - cnt_t'(pop);
      unfilled_q <= unfilled_q + cnt_t'(grant) - cnt_t'(rsp_fill);
    end
  end

endmodule
